// File: rtl/tt_um_pwm_multi_channel_gen.sv
// Multi-channel PWM generator sharing one period counter, with debounced per-channel
// duty buttons and edge/center-aligned counting; duty and mode only take effect at a period boundary.
//   state            | meaning
//   mode_q=0         | edge-aligned: cnt 0..PERIOD-1, wrap
//   mode_q=1,dir_q=0 | center-aligned, counting up (holds PERIOD-1 one clk to flip)
//   mode_q=1,dir_q=1 | center-aligned, counting down (boundary at 0)
module tt_um_pwm_multi_channel_gen #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 8,
  parameter int PERIOD     = 100,
  parameter int STEP       = 10,
  parameter int DUTY_RESET = 50,
  parameter int DEB_DIV    = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode,
  input  logic [CHANNELS-1:0] inc_btn,
  input  logic [CHANNELS-1:0] dec_btn,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic [CNT_W-1:0]    duty_ch0
);

  localparam int               DEB_W     = $clog2(DEB_DIV);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PERIOD_X  = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X    = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W-1:0] DUTY_RST  = CNT_W'(DUTY_RESET);

  logic [DEB_W-1:0]                deb_q, deb_d;
  logic [CHANNELS-1:0]             inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
  logic [CHANNELS-1:0]             dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  active_q, active_d;
  logic [CHANNELS-1:0][CNT_W:0]    up_x;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            dir_q, dir_d;
  logic                            mode_q, mode_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            tick_q, tick_d;
  logic                            slow_en, boundary;
  logic [CHANNELS-1:0]             inc_press, dec_press;

  // Debounce sampling and shadow duty update
  always_comb begin
    slow_en   = ena && (deb_q == DEB_LAST);
    deb_d     = deb_q;
    inc_s1_d  = inc_s1_q;
    inc_s2_d  = inc_s2_q;
    dec_s1_d  = dec_s1_q;
    dec_s2_d  = dec_s2_q;
    if (ena) deb_d = slow_en ? '0 : deb_q + 1'b1;
    if (slow_en) begin
      inc_s1_d = inc_btn;
      inc_s2_d = inc_s1_q;
      dec_s1_d = dec_btn;
      dec_s2_d = dec_s1_q;
    end
    inc_press = inc_s1_q & ~inc_s2_q & {CHANNELS{slow_en}};
    dec_press = dec_s1_q & ~dec_s2_q & {CHANNELS{slow_en}};
    shadow_d  = shadow_q;
    up_x      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      up_x[i] = {1'b0, shadow_q[i]} + STEP_X;
      if (inc_press[i] && !dec_press[i])
        shadow_d[i] = (up_x[i] > PERIOD_X) ? PERIOD_X[CNT_W-1:0] : up_x[i][CNT_W-1:0];
      else if (dec_press[i] && !inc_press[i])
        shadow_d[i] = ({1'b0, shadow_q[i]} < STEP_X) ? '0 : shadow_q[i] - STEP_X[CNT_W-1:0];
    end
  end

  // Next state; every boundary restarts at cnt=0 counting up, which also covers a mode change
  always_comb begin
    boundary = mode_q ? ((cnt_q == '0) && dir_q) : (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    active_d = active_q;
    mode_d   = mode_q;
    if (ena) begin
      if (boundary) begin
        cnt_d    = '0;
        dir_d    = 1'b0;
        active_d = shadow_q;
        mode_d   = mode;
      end else if (!mode_q || !dir_q) begin
        if (mode_q && (cnt_q == CNT_LAST)) dir_d = 1'b1;
        else                               cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_d[i] = ena && (cnt_q < active_q[i]);
    tick_d = ena && boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q    <= '0;
      inc_s1_q <= '0;
      inc_s2_q <= '0;
      dec_s1_q <= '0;
      dec_s2_q <= '0;
      shadow_q <= {CHANNELS{DUTY_RST}};
      active_q <= {CHANNELS{DUTY_RST}};
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      pwm_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      deb_q    <= deb_d;
      inc_s1_q <= inc_s1_d;
      inc_s2_q <= inc_s2_d;
      dec_s1_q <= dec_s1_d;
      dec_s2_q <= dec_s2_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign duty_ch0    = active_q[0];

endmodule

// File: tb/tb_tt_um_pwm_multi_channel_gen.sv
// Bench for the multi-channel PWM generator: a period-phase reference model checked every cycle,
// plus directed scenarios with hand-computed duty, high-time and tick-spacing expectations.
module tb_tt_um_pwm_multi_channel_gen;
  localparam int CH = 2, CW = 8, PER = 10, STP = 1, DRST = 5, DDIV = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          ena = 1;
  logic          mode = 0;
  logic [CH-1:0] inc_btn = '0;
  logic [CH-1:0] dec_btn = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic [CW-1:0] duty_ch0;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 0;

  tt_um_pwm_multi_channel_gen #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD(PER), .STEP(STP), .DUTY_RESET(DRST), .DEB_DIV(DDIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .pwm_out(pwm_out), .period_tick(period_tick), .duty_ch0(duty_ch0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period, sampled button history, shadow/active duty
  int      m_deb = 0;
  bit      m_i1[CH], m_i2[CH], m_d1[CH], m_d2[CH];
  int      m_shadow[CH] = '{DRST, DRST};
  int      m_active[CH] = '{DRST, DRST};
  bit      m_mode = 0;
  int      m_phase = 0;
  bit [CH-1:0] m_pwm = '0;
  bit      m_tick = 0;
  bit      m_slow, m_bnd, m_pi, m_pd;
  int      m_plen, m_level;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_deb = 0; m_mode = 0; m_phase = 0; m_pwm = '0; m_tick = 0;
      for (int i = 0; i < CH; i++) begin
        m_i1[i] = 0; m_i2[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
        m_shadow[i] = DRST; m_active[i] = DRST;
      end
    end else if (!ena) begin
      m_pwm = '0;
      m_tick = 0;
    end else begin
      m_slow  = (m_deb == DDIV - 1);
      m_deb   = m_slow ? 0 : m_deb + 1;
      m_plen  = m_mode ? 2 * PER : PER;
      m_level = (!m_mode || m_phase < PER) ? m_phase : 2 * PER - 1 - m_phase;
      m_bnd   = (m_phase == m_plen - 1);
      for (int i = 0; i < CH; i++) m_pwm[i] = (m_level < m_active[i]);
      m_tick = m_bnd;
      if (m_bnd) begin
        for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
        m_mode  = mode;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      if (m_slow) begin
        for (int i = 0; i < CH; i++) begin
          m_pi = m_i1[i] && !m_i2[i];
          m_pd = m_d1[i] && !m_d2[i];
          if (m_pi && !m_pd)      m_shadow[i] = (m_shadow[i] + STP > PER) ? PER : m_shadow[i] + STP;
          else if (m_pd && !m_pi) m_shadow[i] = (m_shadow[i] - STP < 0) ? 0 : m_shadow[i] - STP;
          m_i2[i] = m_i1[i]; m_i1[i] = inc_btn[i];
          m_d2[i] = m_d1[i]; m_d1[i] = dec_btn[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pwm_out", pwm_out, m_pwm);
      check("model_period_tick", period_tick, m_tick);
      check("model_duty_ch0", duty_ch0, m_active[0]);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out[ch]) hi++;
    end
  endtask

  task automatic tick_gap(output int gap);
    int w;
    w = 0;
    while (!period_tick && w < 60) begin @(negedge clk); w++; end
    gap = 0;
    do begin @(negedge clk); gap++; end while (!period_tick && gap < 60);
    if (w >= 60) check("tick_wait_timeout", w, 0);
  endtask

  task automatic press(input bit is_inc, input int ch);
    if (is_inc) inc_btn[ch] = 1; else dec_btn[ch] = 1;
    clks(6);
    if (is_inc) inc_btn[ch] = 0; else dec_btn[ch] = 0;
    clks(6);
  endtask

  initial begin
    int hi, gap, w;
    @(posedge clk);
    chk_en = 1;
    clks(2);
    check("reset_duty_ch0", duty_ch0, 5);
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_tick", period_tick, 0);
    rst_n = 1;

    // 1: edge mode, duty 5 of 10
    clks(2);
    count_high(0, 10, hi); check("t1_ch0_high", hi, 5);
    count_high(1, 10, hi); check("t1_ch1_high", hi, 5);
    tick_gap(gap);         check("t1_tick_gap", gap, 10);

    // 2: long hold is a single step
    inc_btn[0] = 1; clks(40); inc_btn[0] = 0; clks(30);
    check("t2_duty_ch0", duty_ch0, 6);
    count_high(1, 10, hi); check("t2_ch1_high", hi, 5);
    count_high(0, 10, hi); check("t2_ch0_high", hi, 6);

    // 3: saturate at PERIOD then floor at 0
    repeat (11) press(1, 0);
    clks(25);
    check("t3_duty_max", duty_ch0, 10);
    count_high(0, 20, hi); check("t3_ch0_const1", hi, 20);
    repeat (11) press(0, 0);
    clks(25);
    check("t3_duty_min", duty_ch0, 0);
    count_high(0, 20, hi); check("t3_ch0_const0", hi, 0);

    // 4: simultaneous inc/dec leaves duty alone
    inc_btn[1] = 1; dec_btn[1] = 1; clks(6);
    inc_btn[1] = 0; dec_btn[1] = 0; clks(25);
    count_high(1, 10, hi); check("t4_ch1_high", hi, 5);

    // 5: center mode requested mid-period
    clks(3);
    mode = 1;
    clks(25);
    tick_gap(gap);         check("t5_tick_gap", gap, 20);
    count_high(1, 20, hi); check("t5_ch1_high", hi, 10);

    // 6: freeze, then async reset mid-period
    ena = 0;
    clks(7);
    check("t6_frozen_duty", duty_ch0, 0);
    check("t6_frozen_pwm", pwm_out, 0);
    ena = 1;
    w = 0;
    while (!pwm_out[1] && w < 40) begin @(negedge clk); w++; end
    check("t6_pwm_high_before_reset", pwm_out[1], 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_async_pwm", pwm_out, 0);
    check("t6_async_tick", period_tick, 0);
    check("t6_async_duty", duty_ch0, 5);
    mode = 0;
    clks(2);
    rst_n = 1;
    clks(2);
    count_high(0, 10, hi); check("t6_restart_ch0_high", hi, 5);
    tick_gap(gap);         check("t6_restart_tick_gap", gap, 10);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
